xyz_rr_connect: RTL and testbench

//  - Parametrised N-channel connector for {x,y,z} coordinate bundles; merges NUM_CH

---
 rtl/xyz_pkg.sv | 25 ++
 rtl/xyz_rr_connect_rr_arbiter.sv | 55 +++++
 rtl/xyz_rr_connect.sv | 140 ++++++++++++++
 tb/tb_xyz_rr_connect.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/xyz_pkg.sv
// rtl/xyz_pkg.sv - shared types and helpers for the xyz round-robin connector
`ifndef XYZ_SHAPE_T
`define XYZ_SHAPE_T(WIDTH) struct packed { logic [(WIDTH)-1:0] x; logic [(WIDTH)-1:0] y; logic [(WIDTH)-1:0] z; }
`endif

package xyz_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  // Channel index width; a single channel still needs one bit.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // (a + b) mod n for a, b already below n.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/xyz_rr_connect_rr_arbiter.sv
// rtl/xyz_rr_connect_rr_arbiter.sv - round-robin arbiter owning the priority pointer
module rr_arbiter
  import xyz_pkg::*;
#(
  parameter int N         = 2,
  parameter int START_IDX = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N-1:0]              req_i,
  input  logic                      en_i,
  input  logic                      adv_i,
  output logic [N-1:0]              gnt_o,
  output logic [ch_idx_w(N)-1:0]    gnt_idx_o
);

  localparam int CW = ch_idx_w(N);

  logic [CW-1:0] ptr_q, ptr_d;
  logic          found;

  // First requester at or above the pointer, wrapping; gnt is masked by en_i.
  always_comb begin
    found     = 1'b0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        if (!found && req_i[k] && (k == wrap_add(int'(ptr_q), i, N))) begin
          found     = 1'b1;
          gnt_o[k]  = en_i;
          gnt_idx_o = CW'(k);
        end
      end
    end
  end

  // The channel after the accepted one gets top priority next.
  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      ptr_d = (int'(gnt_idx_o) == N - 1) ? '0 : gnt_idx_o + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= CW'(START_IDX);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/xyz_rr_connect.sv
// rtl/xyz_rr_connect.sv - N-channel xyz merger with round-robin grant and packet lock
module xyz_rr_connect
  import xyz_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int W         = 8,
  parameter int START_IDX = 0,
  parameter int LOCK_PKT  = 0
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_CH-1:0]                 in_valid_i,
  output logic [NUM_CH-1:0]                 in_ready_o,
  input  logic [NUM_CH-1:0]                 in_last_i,
  input  logic [NUM_CH-1:0][W-1:0]          in_x_i,
  input  logic [NUM_CH-1:0][W-1:0]          in_y_i,
  input  logic [NUM_CH-1:0][W-1:0]          in_z_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic                              out_last_o,
  output logic [W-1:0]                      out_x_o,
  output logic [W-1:0]                      out_y_o,
  output logic [W-1:0]                      out_z_o,
  output logic [ch_idx_w(NUM_CH)-1:0]       out_ch_o
);

  localparam int CW = ch_idx_w(NUM_CH);

  typedef `XYZ_SHAPE_T(W) shape_t;

  shape_t        out_q, out_d, sel;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [CW-1:0] out_ch_q, out_ch_d;
  lock_state_e   state_q, state_d;
  logic [CW-1:0] lock_ch_q, lock_ch_d;

  logic              ld, accept, sel_last;
  logic [NUM_CH-1:0] req, gnt;
  logic [CW-1:0]     gnt_idx;

  // Output slot can take a new beat when empty or being drained this cycle.
  assign ld = !out_valid_q || out_ready_i;

  // While locked only the owning channel may request, even if it is idle.
  always_comb begin
    req = in_valid_i;
    if (state_q == LOCKED) begin
      req = in_valid_i & (NUM_CH'(1) << lock_ch_q);
    end
  end

  rr_arbiter #(
    .N         (NUM_CH),
    .START_IDX (START_IDX)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req),
    .en_i      (ld),
    .adv_i     (accept),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  // Grant drives in_ready; a lone channel is simply gated by the load enable.
  always_comb begin
    in_ready_o = (NUM_CH == 1) ? {NUM_CH{ld}} : gnt;
    accept     = |(in_valid_i & in_ready_o);
    sel.x      = in_x_i[gnt_idx];
    sel.y      = in_y_i[gnt_idx];
    sel.z      = in_z_i[gnt_idx];
    sel_last   = in_last_i[gnt_idx];
  end

  // Lock FSM: a non-last beat claims the channel until its last beat is taken.
  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    if ((LOCK_PKT != 0) && accept) begin
      case (state_q)
        IDLE: begin
          if (!sel_last) begin
            state_d   = LOCKED;
            lock_ch_d = gnt_idx;
          end
        end
        LOCKED: begin
          if (sel_last) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output register next state: load on ld, otherwise hold the pending beat.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    if (ld) begin
      out_valid_d = accept;
      if (accept) begin
        out_d      = sel;
        out_last_d = sel_last;
        out_ch_d   = gnt_idx;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      lock_ch_q   <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign out_x_o     = out_q.x;
  assign out_y_o     = out_q.y;
  assign out_z_o     = out_q.z;
  assign out_ch_o    = out_ch_q;

endmodule

// File: tb/tb_xyz_rr_connect.sv
// tb/tb_xyz_rr_connect.sv - self-checking bench for xyz_rr_connect
module tb_xyz_rr_connect;

  localparam int S4 = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Four-channel locking instance
  logic [3:0]      v4, r4, l4;
  logic [3:0][7:0] x4, y4, z4;
  logic            ov4, ordy4, ol4;
  logic [7:0]      ox4, oy4, oz4;
  logic [1:0]      och4;

  // Three-channel non-locking instance
  logic [2:0]      v3, r3, l3;
  logic [2:0][7:0] x3, y3, z3;
  logic            ov3, ordy3, ol3;
  logic [7:0]      ox3, oy3, oz3;
  logic [1:0]      och3;

  xyz_rr_connect #(.NUM_CH(4), .W(8), .START_IDX(S4), .LOCK_PKT(1)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v4), .in_ready_o(r4), .in_last_i(l4),
    .in_x_i(x4), .in_y_i(y4), .in_z_i(z4), .out_valid_o(ov4), .out_ready_i(ordy4),
    .out_last_o(ol4), .out_x_o(ox4), .out_y_o(oy4), .out_z_o(oz4), .out_ch_o(och4));

  xyz_rr_connect #(.NUM_CH(3), .W(8), .START_IDX(0), .LOCK_PKT(0)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v3), .in_ready_o(r3), .in_last_i(l3),
    .in_x_i(x3), .in_y_i(y3), .in_z_i(z3), .out_valid_o(ov3), .out_ready_i(ordy3),
    .out_last_o(ol3), .out_x_o(ox3), .out_y_o(oy3), .out_z_o(oz3), .out_ch_o(och3));

  int errors = 0;
  int checks = 0;

  // Reference model state for dut4
  int         ptr, lch, mch;
  bit         lk, mv, mlast;
  logic [7:0] mx, my, mz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ptr = S4; lk = 0; lch = 0; mv = 0; mch = 0; mlast = 0;
    mx = '0; my = '0; mz = '0;
  endtask

  function automatic int model_grant(input bit ld);
    if (!ld) return -1;
    if (lk) return v4[2'(lch)] ? lch : -1;
    for (int i = 0; i < 4; i++) begin
      if (v4[2'((ptr + i) % 4)]) return (ptr + i) % 4;
    end
    return -1;
  endfunction

  task automatic model_update(input bit ld, input int g);
    if (ld) begin
      if (g >= 0) begin
        mv = 1; mch = g;
        mx = x4[2'(g)]; my = y4[2'(g)]; mz = z4[2'(g)];
        mlast = l4[2'(g)];
        ptr = (g + 1) % 4;
        if (!lk && !mlast) begin
          lk = 1; lch = g;
        end else if (lk && mlast) begin
          lk = 0;
        end
      end else begin
        mv = 0;
      end
    end
  endtask

  // One clock of dut4 against the model; inputs are set at the preceding negedge.
  task automatic step();
    bit          ld;
    int          g;
    logic [31:0] er;
    #1;
    ld = !mv || ordy4;
    g  = model_grant(ld);
    er = (g >= 0) ? (32'(1) << g) : 32'(0);
    chk("in_ready", 32'(r4), er);
    @(posedge clk);
    model_update(ld, g);
    @(negedge clk);
    chk("out_valid", 32'(ov4), 32'(mv));
    if (mv) begin
      chk("out_ch", 32'(och4), 32'(mch));
      chk("out_last", 32'(ol4), 32'(mlast));
      chk("out_xyz", {8'h0, ox4, oy4, oz4}, {8'h0, mx, my, mz});
    end
  endtask

  int ord[5] = '{2, 3, 0, 1, 2};
  logic [2:0] sv3[6] = '{3'b010, 3'b010, 3'b011, 3'b111, 3'b111, 3'b001};
  int         sg3[6] = '{1, 1, 0, 1, 2, 0};

  initial begin
    rst_n = 1'b0;
    v4 = '0; l4 = '1; ordy4 = 1'b1;
    v3 = '0; l3 = '1; ordy3 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      x4[c] = 8'(8'h40 + c); y4[c] = 8'(8'h50 + c); z4[c] = 8'(8'h60 + c);
    end
    for (int c = 0; c < 3; c++) begin
      x3[c] = 8'(8'h30 + c); y3[c] = 8'(8'h70 + c); z3[c] = 8'(8'h80 + c);
    end
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(ov4), 32'(0));
    chk("rst_out_last", 32'(ol4), 32'(0));
    chk("rst_out_ch", 32'(och4), 32'(0));
    chk("rst_out_xyz", {8'h0, ox4, oy4, oz4}, 32'(0));
    chk("rst_out_valid3", 32'(ov3), 32'(0));
    rst_n = 1'b1;

    // Sparse requests and pointer wrap on the three-channel instance
    for (int k = 0; k < 6; k++) begin
      v3 = sv3[k];
      #1;
      chk("wrap_in_ready", 32'(r3), 32'(1) << sg3[k]);
      @(posedge clk);
      @(negedge clk);
      chk("wrap_out_valid", 32'(ov3), 32'(1));
      chk("wrap_out_ch", 32'(och3), 32'(sg3[k]));
      chk("wrap_out_x", 32'(ox3), 32'(8'h30 + sg3[k]));
    end
    v3 = '0;

    // Reset with everything valid: grants start at START_IDX and rotate
    rst_n = 1'b0;
    v4 = 4'b1111;
    @(negedge clk);
    chk("rst_hold_valid", 32'(ov4), 32'(0));
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("first_cycle_valid", 32'(ov4), 32'(0));
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_order", 32'(och4), 32'(ord[k]));
    end

    // Backpressure holds the beat and in_ready stays zero
    v4 = 4'b0001; x4[0] = 8'h11;
    step();
    chk("bp_first_x", 32'(ox4), 32'(8'h11));
    x4[0] = 8'h22; ordy4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_hold_x", 32'(ox4), 32'(8'h11));
      chk("bp_in_ready", 32'(r4), 32'(0));
    end
    ordy4 = 1'b1;
    step();
    chk("bp_next_x", 32'(ox4), 32'(8'h22));
    v4 = 4'b0000;
    step();
    chk("bp_drain", 32'(ov4), 32'(0));

    // Packet lock: ch1 three beats with a two-cycle gap, ch0 always valid
    x4[0] = 8'hA0; x4[1] = 8'hB1; l4 = 4'b1101; v4 = 4'b0011;
    step();
    chk("lock_b1", 32'(och4), 32'(1));
    x4[1] = 8'hB2;
    step();
    chk("lock_b2", 32'(och4), 32'(1));
    v4 = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("lock_gap", 32'(ov4), 32'(0));
    end
    v4 = 4'b0011; l4 = 4'b1111; x4[1] = 8'hB3;
    step();
    chk("lock_b3", 32'(och4), 32'(1));
    chk("lock_b3_last", 32'(ol4), 32'(1));
    step();
    chk("lock_release", 32'(och4), 32'(0));

    // Asynchronous reset while locked with a pending output beat
    l4 = 4'b1101; v4 = 4'b0011;
    step();
    chk("mid_pkt_valid", 32'(ov4), 32'(1));
    #2 rst_n = 1'b0;
    #1 chk("async_clear", 32'(ov4), 32'(0));
    model_reset();
    v4 = 4'b0000; l4 = 4'b1111;
    #1 rst_n = 1'b1;
    @(negedge clk);
    v4 = 4'b1111;
    step();
    chk("post_rst_start", 32'(och4), 32'(S4));

    // Random traffic against the model
    for (int n = 0; n < 10000; n++) begin
      v4 = 4'($urandom);
      l4 = 4'($urandom);
      for (int c = 0; c < 4; c++) begin
        x4[c] = 8'($urandom); y4[c] = 8'($urandom); z4[c] = 8'($urandom);
      end
      ordy4 = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
